// File: rtl/counter_pkg.sv
// Shared constants for the modulo-N up/down counter: mode encodings and direction values.
package counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the modulo-N counter: next count, next direction, terminal flag.
// COUNTER_PINGPONG_EN enables the ping-pong mode; otherwise mode 10 behaves as up.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             term
);

  // One extra bit so MODULUS = 2^WIDTH does not overflow.
  localparam logic [WIDTH:0] MaxVal  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] PrevVal = (WIDTH+1)'(MODULUS - 2);
  localparam logic [WIDTH:0] One     = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] cnt_up;
  logic [WIDTH:0] nxt;
  logic           unused_msb;

  assign cnt_ext = {1'b0, count};
  // Upward moves treat an out-of-range value as the top of the range.
  assign cnt_up  = (cnt_ext > MaxVal) ? MaxVal : cnt_ext;

  always_comb begin
    nxt      = cnt_ext;
    next_dir = dir;
    term     = 1'b0;
    case (mode)
`ifdef COUNTER_PINGPONG_EN
      MODE_UP: begin
`else
      MODE_UP, MODE_PP: begin
`endif
        next_dir = DIR_UP;
        if (cnt_up == MaxVal) begin
          nxt  = '0;
          term = 1'b1;
        end else begin
          nxt = cnt_up + One;
        end
      end
      MODE_DOWN: begin
        next_dir = DIR_DOWN;
        if (cnt_ext == '0) begin
          nxt  = MaxVal;
          term = 1'b1;
        end else begin
          nxt = cnt_ext - One;
        end
      end
`ifdef COUNTER_PINGPONG_EN
      MODE_PP: begin
        if (dir == DIR_UP) begin
          if (cnt_up == MaxVal) begin
            nxt      = PrevVal;
            next_dir = DIR_DOWN;
            term     = 1'b1;
          end else begin
            nxt = cnt_up + One;
          end
        end else begin
          if (cnt_ext == '0) begin
            nxt      = One;
            next_dir = DIR_UP;
            term     = 1'b1;
          end else begin
            nxt = cnt_ext - One;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  assign next_count = nxt[WIDTH-1:0];
  assign unused_msb = nxt[WIDTH];

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N step counter with up/down/ping-pong/hold modes, preset load, tc pulse and
// saturating wrap count. Ping-pong is compiled in only with COUNTER_PINGPONG_EN.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16,
  parameter int unsigned WRAP_W  = 4
) (
  input  logic              clk_o,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH:0] MaxVal = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              dir_q, dir_d;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic [WIDTH-1:0] next_count;
  logic             next_dir;
  logic             term;
  logic [WIDTH-1:0] load_clamped;

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_q),
    .dir        (dir_q),
    .mode       (mode),
    .next_count (next_count),
    .next_dir   (next_dir),
    .term       (term)
  );

  assign load_clamped = ({1'b0, load_val} > MaxVal) ? MaxVal[WIDTH-1:0] : load_val;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    wraps_d = wraps_q;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = next_count;
      dir_d   = next_dir;
      tc_d    = term;
      if (term && (wraps_q != {WRAP_W{1'b1}})) begin
        wraps_d = wraps_q + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_o or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      tc_q    <= 1'b0;
      wraps_q <= '0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      wraps_q <= wraps_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (MODULUS 10 main instance, MODULUS 16 boundary instance).
module tb_updown_mod_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = MODE_UP;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count, c16;
  logic       dir, d16, tc, t16;
  logic [3:0] wraps, w16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(4)) dut (
    .clk_o(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(count), .dir(dir), .tc(tc), .wraps(wraps)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .WRAP_W(4)) dut16 (
    .clk_o(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(c16), .dir(d16), .tc(t16), .wraps(w16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({count, dir, tc, wraps} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got c=%0d d=%0d t=%0d w=%0d exp all 0", count, dir, tc, wraps);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_down();
    do_reset();
    mode = MODE_DOWN;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'(9 - i) || tc !== (i == 0)) begin
        errors++;
        $display("FAIL down step %0d got c=%0d tc=%0d exp c=%0d tc=%0d", i, count, tc, 9 - i, i == 0);
      end
    end
    checks++;
    if (wraps !== 4'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL down_end got w=%0d d=%0d exp w=1 d=1", wraps, dir);
    end
  endtask

  task automatic test_up();
    do_reset();
    mode = MODE_UP;
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (count !== 4'(i % 10) || tc !== (i == 10)) begin
        errors++;
        $display("FAIL up step %0d got c=%0d tc=%0d exp c=%0d tc=%0d", i, count, tc, i % 10, i == 10);
      end
    end
    checks++;
    if (wraps !== 4'd1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL up_end got w=%0d d=%0d exp w=1 d=0", wraps, dir);
    end
  endtask

  task automatic test_pingpong();
    int exp_c[4];
    int exp_t[4];
    int exp_d[4];
`ifdef COUNTER_PINGPONG_EN
    exp_c = '{9, 8, 7, 6};
    exp_d = '{0, 1, 1, 1};
`else
    exp_c = '{9, 0, 1, 2};
    exp_d = '{0, 0, 0, 0};
`endif
    exp_t = '{0, 1, 0, 0};
    do_reset();
    load = 1'b1;
    load_val = 4'd8;
    tick();
    load = 1'b0;
    mode = MODE_PP;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 4'(exp_c[i]) || tc !== 1'(exp_t[i]) || dir !== 1'(exp_d[i])) begin
        errors++;
        $display("FAIL pingpong step %0d got c=%0d t=%0d d=%0d exp c=%0d t=%0d d=%0d",
                 i, count, tc, dir, exp_c[i], exp_t[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    mode = MODE_DOWN;
    en = 1'b1;
    tick();
    load = 1'b1;
    load_val = 4'd15;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 4'd9 || tc !== 1'b0 || dir !== 1'b1 || wraps !== 4'd1) begin
      errors++;
      $display("FAIL load_clamp got c=%0d t=%0d d=%0d w=%0d exp c=9 t=0 d=1 w=1",
               count, tc, dir, wraps);
    end
  endtask

  task automatic test_hold_idle();
    do_reset();
    load = 1'b1;
    load_val = 4'd5;
    tick();
    load = 1'b0;
    mode = MODE_HOLD;
    en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd5 || tc !== 1'b0) begin
      errors++;
      $display("FAIL hold got c=%0d t=%0d exp c=5 t=0", count, tc);
    end
    mode = MODE_UP;
    en = 1'b0;
    tick();
    checks++;
    if (count !== 4'd5 || tc !== 1'b0) begin
      errors++;
      $display("FAIL idle got c=%0d t=%0d exp c=5 t=0", count, tc);
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = MODE_UP;
    en = 1'b1;
    tick();
    tick();
    mode = MODE_DOWN;
    tick();
    checks++;
    if (count !== 4'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL mode_to_down got c=%0d d=%0d exp c=1 d=1", count, dir);
    end
    mode = MODE_PP;
    tick();
`ifdef COUNTER_PINGPONG_EN
    checks++;
    if (count !== 4'd0 || dir !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL mode_to_pp got c=%0d d=%0d t=%0d exp c=0 d=1 t=0", count, dir, tc);
    end
    tick();
    checks++;
    if (count !== 4'd1 || dir !== 1'b0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL pp_bounce_low got c=%0d d=%0d t=%0d exp c=1 d=0 t=1", count, dir, tc);
    end
`else
    checks++;
    if (count !== 4'd2 || tc !== 1'b0) begin
      errors++;
      $display("FAIL mode_to_pp_as_up got c=%0d t=%0d exp c=2 t=0", count, tc);
    end
`endif
  endtask

  task automatic test_full_range();
    do_reset();
    mode = MODE_UP;
    en = 1'b1;
    repeat (15) tick();
    checks++;
    if (c16 !== 4'd15 || t16 !== 1'b0) begin
      errors++;
      $display("FAIL mod16_top got c=%0d t=%0d exp c=15 t=0", c16, t16);
    end
    tick();
    checks++;
    if (c16 !== 4'd0 || t16 !== 1'b1 || w16 !== 4'd1) begin
      errors++;
      $display("FAIL mod16_wrap got c=%0d t=%0d w=%0d exp c=0 t=1 w=1", c16, t16, w16);
    end
    load = 1'b1;
    load_val = 4'd15;
    tick();
    load = 1'b0;
    checks++;
    if (c16 !== 4'd15 || count !== 4'd9) begin
      errors++;
      $display("FAIL mod16_load got c16=%0d c10=%0d exp c16=15 c10=9", c16, count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mode = MODE_UP;
    en = 1'b1;
    for (int w = 1; w <= 20; w++) begin
      repeat (10) tick();
      checks++;
      if (wraps !== 4'((w > 15) ? 15 : w) || count !== 4'd0 || tc !== 1'b1) begin
        errors++;
        $display("FAIL saturate wrap %0d got w=%0d c=%0d t=%0d exp w=%0d c=0 t=1",
                 w, wraps, count, tc, (w > 15) ? 15 : w);
      end
    end
  endtask

  task automatic test_async_reset();
    // Continues from the saturated state left by test_saturate.
    mode = MODE_DOWN;
    en = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({count, dir, tc, wraps} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got c=%0d d=%0d t=%0d w=%0d exp all 0", count, dir, tc, wraps);
    end
    tick();
    checks++;
    if ({count, dir, tc, wraps} !== 10'd0) begin
      errors++;
      $display("FAIL reset_held got c=%0d d=%0d t=%0d w=%0d exp all 0", count, dir, tc, wraps);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (count !== 4'd9 || tc !== 1'b1 || wraps !== 4'd1) begin
      errors++;
      $display("FAIL reset_release got c=%0d t=%0d w=%0d exp c=9 t=1 w=1", count, tc, wraps);
    end
  endtask

  initial begin
    test_reset();
    test_down();
    test_up();
    test_pingpong();
    test_load_clamp();
    test_hold_idle();
    test_mode_change();
    test_full_range();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
